// File: rtl/sd_image_responder.sv
// Serves 512-byte SD sector reads/writes from a disk image held in SDRAM,
// one byte per SDRAM port2 transaction (toggle req/ack handshake).
module sd_image_responder #(
  parameter logic [24:0] BASE_ADDR = 25'h0100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        img_wp,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_dout,
  output logic        sd_dout_strobe,
  input  logic [7:0]  sd_din,
  output logic        sd_din_strobe,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_a,
  output logic [1:0]  mem_ds,
  output logic        mem_we,
  output logic [15:0] mem_d,
  input  logic [15:0] mem_q,
  output logic [3:0]  dbg_state_o
);

  // mem_req/mem_ack: a request is outstanding while mem_req != mem_ack; the
  // memory completes it by toggling mem_ack (read data on mem_q is valid then).
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_REQ  = 4'd1,
    RD_WAIT = 4'd2,
    RD_STB  = 4'd3,
    WR_STB  = 4'd4,
    WR_CAP  = 4'd5,
    WR_REQ  = 4'd6,
    WR_WAIT = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic        mnt_q;
  logic [22:0] sectors_q;
  logic [15:0] lba_q, lba_d;
  logic        valid_q, valid_d;
  logic [8:0]  idx_q, idx_d;
  logic        ack_q, ack_d;
  logic [7:0]  dout_q, dout_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_ds_q, mem_ds_d;
  logic [23:0] mem_a_q, mem_a_d;
  logic [15:0] mem_d_q, mem_d_d;
  logic [24:0] byte_addr;
  logic        last_byte;
  logic        unused_size_bits;

  // Only lba[15:0] reaches the 25-bit address; the full lba is range-checked at accept.
  assign byte_addr        = BASE_ADDR + {lba_q, 9'd0} + {16'd0, idx_q};
  assign last_byte        = (idx_q == 9'd511);
  assign unused_size_bits = ^img_size[8:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      mnt_q     <= 1'b0;
      sectors_q <= 23'd0;
      lba_q     <= 16'd0;
      valid_q   <= 1'b0;
      idx_q     <= 9'd0;
      ack_q     <= 1'b0;
      dout_q    <= 8'd0;
      mem_req_q <= mem_ack;
      mem_we_q  <= 1'b0;
      mem_ds_q  <= 2'b00;
      mem_a_q   <= 24'd0;
      mem_d_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      if (img_mounted) begin
        mnt_q     <= 1'b1;
        sectors_q <= img_size[31:9];
      end
      lba_q     <= lba_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      mem_ds_q  <= mem_ds_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ack_d     = ack_q;
    dout_d    = dout_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_ds_d  = mem_ds_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba[15:0];
          // Validity is frozen here so a remount mid-transfer cannot change it.
          valid_d = mnt_q && (sd_lba < {9'd0, sectors_q});
          ack_d   = 1'b1;
          idx_d   = 9'd0;
          state_d = sd_rd ? RD_REQ : WR_STB;
        end
      end
      RD_REQ: begin
        if (valid_q) begin
          mem_req_d = ~mem_req_q;
          mem_we_d  = 1'b0;
          mem_a_d   = byte_addr[24:1];
          mem_ds_d  = byte_addr[0] ? 2'b10 : 2'b01;
          state_d   = RD_WAIT;
        end else begin
          dout_d  = 8'h00;
          state_d = RD_STB;
        end
      end
      RD_WAIT: begin
        if (mem_ack == mem_req_q) begin
          dout_d  = mem_ds_q[1] ? mem_q[15:8] : mem_q[7:0];
          state_d = RD_STB;
        end
      end
      RD_STB: begin
        if (last_byte) begin
          ack_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = RD_REQ;
        end
      end
      WR_STB: state_d = WR_CAP;
      WR_CAP: begin
        mem_d_d = {sd_din, sd_din};
        if (valid_q && !img_wp) begin
          state_d = WR_REQ;
        end else if (last_byte) begin
          ack_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = WR_STB;
        end
      end
      WR_REQ: begin
        mem_req_d = ~mem_req_q;
        mem_we_d  = 1'b1;
        mem_a_d   = byte_addr[24:1];
        mem_ds_d  = byte_addr[0] ? 2'b10 : 2'b01;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_ack == mem_req_q) begin
          if (last_byte) begin
            ack_d   = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = WR_STB;
          end
        end
      end
      DONE: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd_ack         = ack_q;
  assign sd_buff_addr   = idx_q;
  assign sd_dout        = dout_q;
  assign sd_dout_strobe = (state_q == RD_STB);
  assign sd_din_strobe  = (state_q == WR_STB);
  assign mem_req        = mem_req_q;
  assign mem_a          = mem_a_q;
  assign mem_ds         = mem_ds_q;
  assign mem_we         = mem_we_q;
  assign mem_d          = mem_d_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sd_image_responder.sv
// Bench for sd_image_responder: SDRAM port2 model with variable ack delay,
// SD requester driver, and a sector-level reference for expected bytes.
module tb_sd_image_responder;

  localparam int BASE = 'h100000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = 32'd0;
  logic        img_wp = 1'b0;
  logic [31:0] sd_lba = 32'd0;
  logic        sd_rd = 1'b0, sd_wr = 1'b0;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din = 8'd0;
  logic        sd_din_strobe;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_a;
  logic [1:0]  mem_ds;
  logic        mem_we;
  logic [15:0] mem_d;
  logic [15:0] mem_q = 16'd0;
  logic [3:0]  dbg_state;

  sd_image_responder dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .img_wp(img_wp), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe),
    .sd_din(sd_din), .sd_din_strobe(sd_din_strobe), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_a(mem_a), .mem_ds(mem_ds), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- bench state ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  sd_mem [int];
  logic [7:0]  exp_q [$];
  logic [8:0]  got_addr [$];
  logic [7:0]  got_data [$];
  logic [8:0]  din_addr [$];
  int          wr_log [$];
  int          toggles = 0;
  int          last_stb = 0, fall_cyc = 0;
  bit          rand_dly = 0;
  bit          din_mode = 0;
  bit          tb_mnt = 0;
  logic [31:0] tb_sectors = 32'd0;
  bit          last_valid = 0;

  function automatic logic [7:0] mem_byte(input int a);
    if (sd_mem.exists(a)) return sd_mem[a];
    return 8'(a - BASE);
  endfunction

  function automatic int baddr(input logic [31:0] lba, input int i);
    logic [24:0] t;
    t = 25'(BASE) + 25'(lba * 512) + 25'(i);
    return int'(t);
  endfunction

  function automatic logic [7:0] din_val(input logic [8:0] a);
    return din_mode ? (a[7:0] ^ 8'h5A) : ~a[7:0];
  endfunction

  // ---------------- SDRAM port2 model ----------------
  int mdl_dly = 0, mdl_a = 0;
  bit mdl_busy = 0;
  always @(posedge clk_sys) begin
    if (reset) begin
      mdl_busy = 0;
    end else if (mdl_busy) begin
      mdl_dly--;
      if (mdl_dly == 0) begin
        mdl_busy = 0;
        mdl_a = int'({mem_a, 1'b0});
        if (mem_we) begin
          if (mem_ds == 2'b01) wr_log.push_back(mdl_a);
          else if (mem_ds == 2'b10) wr_log.push_back(mdl_a + 1);
          else wr_log.push_back(-1);
          if (mem_ds[0]) sd_mem[mdl_a] = mem_d[7:0];
          if (mem_ds[1]) sd_mem[mdl_a + 1] = mem_d[15:8];
        end else begin
          mem_q <= {mem_byte(mdl_a + 1), mem_byte(mdl_a)};
        end
        mem_ack <= ~mem_ack;
      end
    end else if (mem_req !== mem_ack) begin
      mdl_busy = 1;
      mdl_dly = rand_dly ? $urandom_range(1, 20) : 1;
    end
  end

  logic last_req = 1'b0;
  always @(posedge clk_sys) begin
    if (!reset && mem_req !== last_req) toggles++;
    last_req = mem_req;
  end

  // ---------------- monitor ----------------
  logic prev_ack = 1'b0;
  always @(negedge clk_sys) begin
    cyc++;
    if (!reset) begin
      if (sd_dout_strobe === 1'b1) begin
        got_addr.push_back(sd_buff_addr);
        got_data.push_back(sd_dout);
        last_stb = cyc;
      end
      if (sd_din_strobe === 1'b1) din_addr.push_back(sd_buff_addr);
      if (prev_ack === 1'b1 && sd_ack === 1'b0) fall_cyc = cyc;
    end
    prev_ack = sd_ack;
  end

  // Requester write data: valid only in the cycle after each din strobe.
  logic [8:0] drv_a;
  always begin
    @(negedge clk_sys);
    if (sd_din_strobe === 1'b1) begin
      drv_a = sd_buff_addr;
      @(posedge clk_sys); #1 sd_din = din_val(drv_a);
      @(posedge clk_sys); #1 sd_din = 8'($urandom);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mount(input logic [31:0] sz);
    @(negedge clk_sys); img_mounted = 1'b1; img_size = sz;
    @(negedge clk_sys); img_mounted = 1'b0;
    tb_mnt = 1; tb_sectors = sz >> 9;
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba);
    int n;
    got_addr.delete(); got_data.delete(); din_addr.delete(); wr_log.delete();
    toggles = 0; fall_cyc = 0; last_stb = 0;
    last_valid = tb_mnt && (lba < tb_sectors);
    @(negedge clk_sys); sd_lba = lba; sd_rd = rd; sd_wr = wr;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (sd_ack !== 1'b1 && n < 20);
    sd_rd = 1'b0; sd_wr = 1'b0;
    checks++;
    if (sd_ack !== 1'b1) begin
      errors++; $display("FAIL ack_rise: sd_ack=%b, required 1", sd_ack); return;
    end
    n = 0;
    while (sd_ack === 1'b1 && n < 20000) begin @(negedge clk_sys); n++; end
    checks++;
    if (sd_ack !== 1'b0) begin errors++; $display("FAIL ack_fall_timeout: sd_ack=%b, required 0", sd_ack); end
    @(negedge clk_sys);
  endtask

  task automatic build_rd_exp(input logic [31:0] lba, input bit valid);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(valid ? mem_byte(baddr(lba, i)) : 8'h00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b, required 0", sd_ack); end
    checks++; if ({sd_dout_strobe, sd_din_strobe} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b, required 00", {sd_dout_strobe, sd_din_strobe}); end
    checks++; if (sd_buff_addr !== 9'd0 || sd_dout !== 8'd0) begin errors++; $display("FAIL rst_buff: addr=%0d dout=%h, required 0/00", sd_buff_addr, sd_dout); end
    checks++; if (mem_we !== 1'b0 || mem_ds !== 2'b00) begin errors++; $display("FAIL rst_mem_ctl: we=%b ds=%b, required 0/00", mem_we, mem_ds); end
    checks++; if (mem_a !== 24'd0 || mem_d !== 16'd0) begin errors++; $display("FAIL rst_mem_ad: a=%h d=%h, required 0/0", mem_a, mem_d); end
    checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL rst_req: req=%b ack=%b, required equal", mem_req, mem_ack); end
    reset = 1'b0; tb_mnt = 0;
    repeat (2) @(negedge clk_sys);
    checks++; if (sd_ack !== 1'b0 || mem_req !== mem_ack) begin errors++; $display("FAIL post_rst_idle: ack=%b req=%b ack_in=%b, required 0 and equal", sd_ack, mem_req, mem_ack); end
  endtask

  task automatic test_read(input logic [31:0] lba, input string nm);
    xfer(1'b1, 1'b0, lba);
    build_rd_exp(lba, last_valid);
    checks++;
    if (got_data.size() != 512) begin errors++; $display("FAIL %s_count: got %0d strobes, required 512", nm, got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 512; i++) begin
      checks++;
      if (got_addr[i] !== 9'(i) || got_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: addr=%0d data=%h, required addr=%0d data=%h", nm, i, got_addr[i], got_data[i], i, exp_q[i]);
      end
    end
    checks++;
    if (fall_cyc != last_stb + 1) begin errors++; $display("FAIL %s_ack_fall: fell at %0d, required %0d", nm, fall_cyc, last_stb + 1); end
    checks++;
    if (toggles != (last_valid ? 512 : 0)) begin errors++; $display("FAIL %s_toggles: got %0d, required %0d", nm, toggles, last_valid ? 512 : 0); end
  endtask

  task automatic test_write();
    din_mode = 0;
    xfer(1'b0, 1'b1, 32'd1);
    checks++;
    if (din_addr.size() != 512 || toggles != 512 || wr_log.size() != 512) begin
      errors++; $display("FAIL wr_counts: din=%0d toggles=%0d writes=%0d, required 512 each", din_addr.size(), toggles, wr_log.size());
    end
    for (int i = 0; i < 512 && i < wr_log.size() && i < din_addr.size(); i++) begin
      checks++;
      if (din_addr[i] !== 9'(i) || wr_log[i] != BASE + 512 + i || mem_byte(BASE + 512 + i) !== ~8'(i)) begin
        errors++;
        $display("FAIL wr_byte%0d: din_addr=%0d wr_addr=%h mem=%h, required %0d %h %h", i, din_addr[i], wr_log[i], mem_byte(BASE + 512 + i), i, BASE + 512 + i, ~8'(i));
      end
    end
    checks++;
    if (mem_byte(BASE + 511) !== 8'hFF || mem_byte(BASE + 1024) !== 8'h00) begin
      errors++; $display("FAIL wr_neighbours: %h %h, required ff 00", mem_byte(BASE + 511), mem_byte(BASE + 1024));
    end
    test_read(32'd1, "wr_readback");
  endtask

  task automatic test_write_protect();
    img_wp = 1'b1; din_mode = 1;
    xfer(1'b0, 1'b1, 32'd1);
    img_wp = 1'b0; din_mode = 0;
    checks++;
    if (din_addr.size() != 512 || toggles != 0 || wr_log.size() != 0) begin
      errors++; $display("FAIL wp_counts: din=%0d toggles=%0d writes=%0d, required 512/0/0", din_addr.size(), toggles, wr_log.size());
    end
    for (int i = 0; i < 512; i += 37) begin
      checks++;
      if (mem_byte(BASE + 512 + i) !== ~8'(i)) begin
        errors++; $display("FAIL wp_mem%0d: got %h, required %h", i, mem_byte(BASE + 512 + i), ~8'(i));
      end
    end
  endtask

  task automatic test_rd_wr_same();
    xfer(1'b1, 1'b1, 32'd2);
    checks++;
    if (din_addr.size() != 0 || got_data.size() != 512 || wr_log.size() != 0) begin
      errors++; $display("FAIL rdwr_prio: din=%0d dout=%0d writes=%0d, required 0/512/0", din_addr.size(), got_data.size(), wr_log.size());
    end
    build_rd_exp(32'd2, 1'b1);
    for (int i = 0; i < got_data.size() && i < 512; i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL rdwr_byte%0d: got %h, required %h", i, got_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_mount_during();
    fork
      test_read(32'd100, "remount_mid");
      begin repeat (300) @(negedge clk_sys); mount(32'd0); end
    join
    test_read(32'd100, "after_remount");
    mount(32'd65536);
  endtask

  task automatic test_random_delay();
    rand_dly = 1;
    test_read(32'd3, "rand_lba3");
    test_read(32'($urandom_range(0, 127)), "rand_lba");
    rand_dly = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    got_addr.delete(); got_data.delete();
    @(negedge clk_sys); sd_lba = 32'd5; sd_rd = 1'b1;
    n = 0;
    while (got_addr.size() < 201 && n < 5000) begin
      @(negedge clk_sys); n++;
      if (sd_ack === 1'b1) sd_rd = 1'b0;
    end
    sd_rd = 1'b0;
    checks++;
    if (got_addr.size() < 201 || got_addr[200] !== 9'd200) begin errors++; $display("FAIL rstmid_reach: strobes=%0d, required byte 200", got_addr.size()); end
    reset = 1'b1;
    @(negedge clk_sys);
    checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b, required 0", sd_ack); end
    checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL rstmid_req: req=%b ack=%b, required equal", mem_req, mem_ack); end
    reset = 1'b0; tb_mnt = 0;
    repeat (25) @(negedge clk_sys);
    checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL rstmid_quiet: req=%b ack=%b, required equal", mem_req, mem_ack); end
    test_read(32'd0, "rstmid_next");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read(32'd0, "unmounted");
    mount(32'd65536);
    test_read(32'd3, "rd_lba3");
    test_write();
    test_write_protect();
    test_read(32'd128, "out_of_range");
    test_rd_wr_same();
    test_mount_during();
    test_random_delay();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
